// File: rtl/divkpn_if.sv
// divkpn_if: handshake bundle between the issuing unit, the divider and the
// result consumer.
//   Issue side  : in_valid, in_ready, x (2K), d (K), in_tag (TAGW)
//   Result side : out_valid, out_ready, q (K), r (K), dz, ovf, out_tag (TAGW)
// master = issuer/consumer (testbench side), slave = the divider.
interface divkpn_if #(
    parameter int K    = 32,
    parameter int TAGW = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [2*K-1:0]  x;
    logic [K-1:0]    d;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [K-1:0]    q;
    logic [K-1:0]    r;
    logic            dz;
    logic            ovf;
    logic [TAGW-1:0] out_tag;

    modport master (
        output in_valid, x, d, in_tag, out_ready,
        input  in_ready, out_valid, q, r, dz, ovf, out_tag
    );

    modport slave (
        input  in_valid, x, d, in_tag, out_ready,
        output in_ready, out_valid, q, r, dz, ovf, out_tag
    );
endinterface

// File: rtl/divkpn.sv
// divkpn: pipelined unsigned restoring divider, 2K-bit dividend by K-bit
// divisor, K-bit quotient and remainder, NSTAGE stages of K/NSTAGE bits each.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - divkpn_if.slave: in_valid/in_ready/x/d/in_tag issue handshake,
//          out_valid/out_ready/q/r/dz/ovf/out_tag result handshake
// K must be >= 2 and divisible by NSTAGE.
module divkpn #(
    parameter int K      = 32,
    parameter int NSTAGE = 4,
    parameter int TAGW   = 8
) (
    input  logic     clk,
    input  logic     rst,
    divkpn_if.slave  bus
);
    localparam int BPS = K / NSTAGE;

    typedef struct packed {
        logic            v;
        logic            dz;
        logic            ovf;
        logic [K-1:0]    rem;
        logic [K-1:0]    lo;
        logic [K-1:0]    quot;
        logic [K-1:0]    dv;
        logic [TAGW-1:0] tag;
    } stage_t;

    // Resolve BPS quotient bits. Flagged operations pass through untouched so
    // that lo still holds the original low dividend word at the output.
    function automatic stage_t resolve(input stage_t s);
        stage_t     o;
        logic [K:0] sh;
        logic [K:0] df;
        o = s;
        if (!(s.dz || s.ovf)) begin
            for (int b = 0; b < BPS; b++) begin
                sh     = {o.rem, o.lo[K-1]};
                df     = sh - {1'b0, o.dv};
                o.lo   = {o.lo[K-2:0], 1'b0};
                // Top bit of the K+1-bit difference is the borrow.
                if (!df[K]) begin
                    o.rem  = df[K-1:0];
                    o.quot = {o.quot[K-2:0], 1'b1};
                end else begin
                    o.rem  = sh[K-1:0];
                    o.quot = {o.quot[K-2:0], 1'b0};
                end
            end
        end
        return o;
    endfunction

    stage_t          st_q [NSTAGE];
    stage_t          st_d [NSTAGE];
    stage_t          last;
    logic            en;

    logic            out_valid_q, out_valid_d;
    logic [K-1:0]    q_q, q_d;
    logic [K-1:0]    r_q, r_d;
    logic            dz_q, dz_d;
    logic            ovf_q, ovf_d;
    logic [TAGW-1:0] tag_q, tag_d;

    // Whole pipeline moves as one; it only stalls when a held result is refused.
    assign en = bus.out_ready || !out_valid_q;

    always_comb begin
        // Stage 1 captures the operands as accepted; flags are fixed here.
        st_d[0].v    = bus.in_valid;
        st_d[0].dz   = (bus.d == '0);
        st_d[0].ovf  = (bus.d != '0) && (bus.x[2*K-1:K] >= bus.d);
        st_d[0].rem  = bus.x[2*K-1:K];
        st_d[0].lo   = bus.x[K-1:0];
        st_d[0].quot = '0;
        st_d[0].dv   = bus.d;
        st_d[0].tag  = bus.in_tag;
        for (int s = 1; s < NSTAGE; s++) begin
            st_d[s] = resolve(st_q[s-1]);
        end

        last        = resolve(st_q[NSTAGE-1]);
        out_valid_d = last.v;
        dz_d        = last.dz;
        ovf_d       = last.ovf;
        tag_d       = last.tag;
        if (last.dz || last.ovf) begin
            q_d = '1;
            r_d = last.lo;
        end else begin
            q_d = last.quot;
            r_d = last.rem;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NSTAGE; s++) begin
                st_q[s] <= '0;
            end
            out_valid_q <= 1'b0;
            q_q         <= '0;
            r_q         <= '0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            tag_q       <= '0;
        end else if (en) begin
            for (int s = 0; s < NSTAGE; s++) begin
                st_q[s] <= st_d[s];
            end
            out_valid_q <= out_valid_d;
            q_q         <= q_d;
            r_q         <= r_d;
            dz_q        <= dz_d;
            ovf_q       <= ovf_d;
            tag_q       <= tag_d;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.q         = q_q;
    assign bus.r         = r_q;
    assign bus.dz        = dz_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_tag   = tag_q;
endmodule

// File: tb/tb_divkpn.sv
module tb_divkpn;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    divkpn_if #(.K(32), .TAGW(8)) bus();
    divkpn #(.K(32), .NSTAGE(4), .TAGW(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ovf;
        logic [7:0]  tag;
    } exp_t;

    typedef struct {
        logic [63:0] x;
        logic [31:0] d;
        logic [7:0]  tag;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ovf;
    } vec_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   retired = 0;
    bit   toggle_on = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [63:0] x, input logic [31:0] d, input logic [7:0] tag);
        exp_t e;
        e.tag = tag;
        e.dz  = 0;
        e.ovf = 0;
        if (d == 0) begin
            e.q = 32'hFFFF_FFFF; e.r = x[31:0]; e.dz = 1;
        end else if (x[63:32] >= d) begin
            e.q = 32'hFFFF_FFFF; e.r = x[31:0]; e.ovf = 1;
        end else begin
            e.q = 32'(x / {32'd0, d});
            e.r = 32'(x % {32'd0, d});
        end
        return e;
    endfunction

    // Scoreboard: pop and compare on every retiring edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
        end else if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_result: got tag %0h q %0h with nothing outstanding", bus.out_tag, bus.q);
            end else begin
                e = exp_q.pop_front();
                retired++;
                check("result{q,r,dz,ovf,tag}", {bus.q, bus.r, bus.dz, bus.ovf, bus.out_tag},
                      {e.q, e.r, e.dz, e.ovf, e.tag});
            end
        end
    end

    // Present an operation and wait for its acceptance; push its expectation then.
    task automatic issue(input logic [63:0] x, input logic [31:0] d, input logic [7:0] tag, input exp_t e);
        bit ok = 0;
        bus.in_valid = 1; bus.x = x; bus.d = d; bus.in_tag = tag;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1; break; end
        end
        if (ok) exp_q.push_back(e);
        else check("accept_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.x = '0; bus.d = '0; bus.in_tag = '0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin ok = 1; break; end
        end
        check("drain_queue_empty", ok, 1);
        @(posedge clk); #1;
    endtask

    // Issue one op and confirm out_valid rises exactly NSTAGE edges later.
    task automatic lat_check(input logic [63:0] x, input logic [31:0] d, input logic [7:0] tag);
        issue(x, d, tag, model(x, d, tag));
        idle();
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("latency_edge%0d_out_valid", i), bus.out_valid, (i == 4));
        end
        drain();
    endtask

    vec_t vecs[10];

    initial begin
        logic [63:0] x;
        logic [31:0] d, hi;
        logic [7:0]  tg;
        int          t0;
        int          n0;
        logic [71:0] cap;

        vecs[0] = '{64'd100, 32'd7, 8'h11, 32'd14, 32'd2, 0, 0};
        vecs[1] = '{64'h1234, 32'd0, 8'h22, 32'hFFFF_FFFF, 32'h1234, 1, 0};
        vecs[2] = '{{32'h5, 32'h9}, 32'd5, 8'h33, 32'hFFFF_FFFF, 32'd9, 0, 1};
        vecs[3] = '{{32'hFFFF_FFFE, 32'hFFFF_FFFF}, 32'hFFFF_FFFF, 8'h44, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0};
        vecs[4] = '{64'hFFFF_FFFF, 32'd1, 8'h55, 32'hFFFF_FFFF, 32'd0, 0, 0};
        vecs[5] = '{{32'h4, 32'h0}, 32'd5, 8'h66, 32'hCCCC_CCCC, 32'd4, 0, 0};
        vecs[6] = '{{32'h5, 32'h0}, 32'd5, 8'h77, 32'hFFFF_FFFF, 32'd0, 0, 1};
        vecs[7] = '{{32'h7, 32'h3}, 32'd0, 8'h88, 32'hFFFF_FFFF, 32'd3, 1, 0};
        vecs[8] = '{64'd0, 32'd3, 8'h99, 32'd0, 32'd0, 0, 0};
        vecs[9] = '{64'd0, 32'd0, 8'hAA, 32'hFFFF_FFFF, 32'd0, 1, 0};

        idle();
        bus.out_ready = 1;
        #12;
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_q_r_tag", {bus.q, bus.r, bus.dz, bus.ovf, bus.out_tag}, 0);
        check("reset_in_ready", bus.in_ready, 1);
        @(posedge clk); #3;
        rst = 0;
        @(posedge clk); #1;

        lat_check(64'd100, 32'd7, 8'h11);

        for (int i = 0; i < 10; i++) begin
            exp_t e;
            e.q = vecs[i].q; e.r = vecs[i].r; e.dz = vecs[i].dz; e.ovf = vecs[i].ovf; e.tag = vecs[i].tag;
            issue(vecs[i].x, vecs[i].d, vecs[i].tag, e);
        end
        idle();
        drain();

        // Back-to-back random stream, consumer always ready.
        n0 = retired;
        t0 = cyc;
        for (int i = 0; i < 1000; i++) begin
            d  = $urandom() | 32'd1;
            hi = $urandom() % d;
            x  = {hi, 32'($urandom())};
            tg = 8'(i);
            issue(x, d, tg, model(x, d, tg));
        end
        check("stream_cycles_for_1000", cyc - t0, 1000);
        idle();
        drain();
        check("stream_retired_count", retired - n0, 1000);

        // Stall with a full pipeline and a result presented.
        for (int i = 0; i < 6; i++) begin
            d = $urandom() | 32'd1; x = {32'($urandom()) % d, 32'($urandom())}; tg = 8'(8'hC0 + i);
            issue(x, d, tg, model(x, d, tg));
        end
        bus.out_ready = 0;
        cap = {bus.q, bus.r, bus.out_tag};
        check("stall_out_valid", bus.out_valid, 1);
        d = 32'd1000; x = 64'd123456; tg = 8'hC6;
        fork
            issue(x, d, tg, model(x, d, tg));
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("stall_in_ready", bus.in_ready, 0);
                    check("stall_output_stable", {bus.out_valid, bus.q, bus.r, bus.out_tag}, {1'b1, cap});
                end
                @(posedge clk); #1;
                bus.out_ready = 1;
            end
        join
        idle();
        drain();

        // Mixed random operands, including flagged ones, with a stalling consumer.
        toggle_on = 1;
        fork
            while (toggle_on) begin
                @(posedge clk); #1;
                if (toggle_on) bus.out_ready = 1'($urandom_range(0, 1));
            end
            begin
                for (int i = 0; i < 200; i++) begin
                    case ($urandom_range(0, 3))
                        0: d = 32'd0;
                        1: d = 32'($urandom_range(1, 20));
                        default: d = $urandom();
                    endcase
                    hi = ($urandom_range(0, 2) == 0) ? 32'($urandom()) : ((d == 0) ? 32'd0 : 32'($urandom()) % d);
                    x  = {hi, 32'($urandom())};
                    tg = 8'($urandom());
                    issue(x, d, tg, model(x, d, tg));
                    if ($urandom_range(0, 4) == 0) begin idle(); @(posedge clk); #1; end
                end
                toggle_on = 0;
            end
        join
        @(posedge clk); #1;
        bus.out_ready = 1;
        idle();
        drain();

        // Reset with operations in flight.
        bus.out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            x = 64'd1000 + 64'(i); d = 32'd3; tg = 8'(8'hE0 + i);
            issue(x, d, tg, model(x, d, tg));
        end
        idle();
        check("pre_reset_out_valid", bus.out_valid, 1);
        #2;
        rst = 1;
        #1;
        check("async_reset_out_valid", bus.out_valid, 0);
        check("async_reset_in_ready", bus.in_ready, 1);
        bus.out_ready = 1;
        @(posedge clk); @(posedge clk); #3;
        rst = 0;
        @(posedge clk); #1;
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (bus.out_valid) seen++;
            end
            check("no_stale_after_reset", seen, 0);
        end
        @(posedge clk); #1;
        lat_check(64'd500, 32'd9, 8'h5A);

        check("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
